lcd_page_scheduler: RTL and testbench
=====================================

# lcd_page_scheduler

Sequences and shares the `write_to_lcd` display between the three KPN data producers: the split-module input entry and the two split outputs. Each producer offers a 16-bit word through a valid/ready handshake. The scheduler holds each word, picks which LCD page to draw next, drives the writer's `show_*` strobes and data buses, waits for the writer to finish, then holds the page for a minimum dwell time.

## Interface

Parameters:
- `DWELL_CYCLES`, 50_000_000: minimum cycles a finished page stays on screen (1 s at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000: maximum wait for `writer_done` after a strobe.
- `CNT_W`, 26: width of the shared dwell/timeout counter; must hold max(DWELL_CYCLES, TIMEOUT_CYCLES).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `entry_valid` in 1: entry producer has a word.
- `entry_data` in 16: entry word.
- `entry_ready` out 1: entry holding register is empty.
- `out1_valid` / `out1_data` [16] / `out1_ready` (out): same handshake for output 1.
- `out2_valid` / `out2_data` [16] / `out2_ready` (out): same handshake for output 2.
- `writer_done` in 1: one-cycle pulse from the writer when the requested line or page has been written.
- `show_entry_1` out 1: one-cycle start strobe for the entry page.
- `show_output_1` out 1: one-cycle start strobe for line 1 of the output page.
- `show_output_2` out 1: one-cycle start strobe for line 2 of the output page.
- `entry_1` out 16: entry word currently displayed; stable from the strobe until the next launch.
- `output_1` out 16: output-1 word currently displayed; same stability rule.
- `output_2` out 16: output-2 word currently displayed; same stability rule.
- `page` out 2: page being drawn or shown. 0 = none, 1 = entry, 2 = outputs.
- `timeout_err` out 1: sticky; set when a writer timeout occurs, cleared only by reset.

## Operation

- Holding registers `hold_entry`, `hold_o1`, `hold_o2`, each with a pending flag.
  - `*_ready` equals the inverse of that register's pending flag.
  - A word is captured and pending is set on `valid && ready`.
- Pending flags clear when their page launches: the held word is copied to the display bus in the same cycle the strobe is issued.
- The entry page is pending when `entry_pend` is set. The output page is pending when `o1_pend | o2_pend`; a line without a new word redraws its last displayed value.
- Arbitration happens in IDLE only.
  - If both pages are pending, the page not shown last wins (round-robin; last-shown is initialised to outputs, so entry wins first).
  - If only one page is pending, it is chosen.
- FSM states: IDLE, E_STROBE, E_WAIT, O1_STROBE, O1_WAIT, O2_STROBE, O2_WAIT, DWELL.
  - IDLE -> E_STROBE or O1_STROBE per arbitration; stays in IDLE while nothing is pending.
  - E_STROBE: `show_entry_1`=1 for one cycle, load `entry_1` -> E_WAIT.
  - E_WAIT -> DWELL on `writer_done`.
  - O1_STROBE: `show_output_1`=1, load `output_1` and `output_2` -> O1_WAIT.
  - O1_WAIT -> O2_STROBE on `writer_done`.
  - O2_STROBE: `show_output_2`=1 -> O2_WAIT.
  - O2_WAIT -> DWELL on `writer_done`.
  - DWELL: count `DWELL_CYCLES`, then update last-shown -> IDLE.
- Any WAIT state goes straight to DWELL when its counter reaches `TIMEOUT_CYCLES`, and sets `timeout_err`.
- The counter resets to 0 on every state entry. It saturates and never wraps.
- `writer_done` outside a WAIT state is ignored.
- New words are accepted in every state, including while their own page is displayed. They stay pending until the next launch and never alter the live `entry_1`/`output_*` buses.

## Timing

- Reset values:
  - all `show_*` = 0, `entry_1` = `output_1` = `output_2` = 0, `page` = 0, `timeout_err` = 0;
  - all `*_ready` = 1, FSM in IDLE.
- Capture-to-strobe latency from IDLE with nothing else pending: the word is captured at edge N, IDLE decides at N+1, and the strobe is high in the cycle after edge N+2.
- Strobes last exactly one cycle. They are never asserted in the same cycle as one another.
- `page` updates on entry to a STROBE state and holds through DWELL. It returns to 0 only on reset.
- `writer_done` in the same cycle as timeout expiry is treated as done: no error.
- Capture and launch of the same register in one cycle: launch uses the old held word, the pending flag stays set (holding the new word), and ready reads 0 the next cycle.
- Reset asserted mid-page: outputs go to reset values asynchronously and any strobe is cut. The writer is expected to be reset together with this block.

## Structure

- Package `lcd_kpn_pkg`: FSM state enum, page encoding constants (PAGE_NONE/ENTRY/OUTPUTS), and the 16-bit word width constant.
- Sub-module `lcd_hold_reg`: one valid/ready holding register with pending flag and launch-clear. Instantiated three times.
- Dwell/timeout counter and FSM are inline.

## Test plan

- Reset then single entry word 0xA5C3 -> one `show_entry_1` pulse, `entry_1`=0xA5C3, `page`=1; after `writer_done`, no further strobe for `DWELL_CYCLES` (bench sets it to 20).
- out1=0x1234 and out2=0x00FF offered together -> `show_output_1`, then after done `show_output_2`; buses 0x1234/0x00FF; `page`=2.
- Entry and output words all pending at once -> entry page first, then output page; a second entry word arriving during dwell is shown after the output page.
- Only out2=0xBEEF new after a previous out1=0x1111 -> output page redraws `output_1`=0x1111 and shows `output_2`=0xBEEF.
- Withhold `writer_done` (bench sets `TIMEOUT_CYCLES` to 30) -> DWELL entered after 30 cycles in WAIT; `timeout_err`=1 and stays high.
- Assert `reset` low during O1_WAIT -> all outputs at reset values in the same cycle; the next word after release is handled normally.

Source files
------------

// File: rtl/lcd_kpn_pkg.sv
// lcd_kpn_pkg: shared word width, page codes and scheduler FSM states
package lcd_kpn_pkg;
   localparam int WORD_W = 16;
   localparam logic [1:0] PAGE_NONE    = 2'd0;
   localparam logic [1:0] PAGE_ENTRY   = 2'd1;
   localparam logic [1:0] PAGE_OUTPUTS = 2'd2;
   typedef enum logic [2:0] {
      S_IDLE, S_E_STROBE, S_E_WAIT, S_O1_STROBE, S_O1_WAIT, S_O2_STROBE, S_O2_WAIT, S_DWELL
   } state_t;
endpackage

// File: rtl/lcd_page_scheduler_if.sv
// lcd_page_scheduler_if: producer handshakes and LCD writer signals of the page scheduler
interface lcd_page_scheduler_if;
   import lcd_kpn_pkg::*;
   logic              entry_valid, entry_ready;
   logic [WORD_W-1:0] entry_data;
   logic              out1_valid, out1_ready;
   logic [WORD_W-1:0] out1_data;
   logic              out2_valid, out2_ready;
   logic [WORD_W-1:0] out2_data;
   logic              writer_done;
   logic              show_entry_1, show_output_1, show_output_2;
   logic [WORD_W-1:0] entry_1, output_1, output_2;
   logic [1:0]        page;
   logic              timeout_err;
   modport master (
      output entry_valid, entry_data, out1_valid, out1_data, out2_valid, out2_data, writer_done,
      input  entry_ready, out1_ready, out2_ready, show_entry_1, show_output_1, show_output_2,
             entry_1, output_1, output_2, page, timeout_err
   );
   modport slave (
      input  entry_valid, entry_data, out1_valid, out1_data, out2_valid, out2_data, writer_done,
      output entry_ready, out1_ready, out2_ready, show_entry_1, show_output_1, show_output_2,
             entry_1, output_1, output_2, page, timeout_err
   );
endinterface

// File: rtl/lcd_hold_reg.sv
// lcd_hold_reg: single-word valid/ready holding register, pending until its page launches
module lcd_hold_reg
   import lcd_kpn_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              valid,
   input  logic [WORD_W-1:0] data,
   output logic              ready,
   input  logic              launch,
   output logic              pend,
   output logic [WORD_W-1:0] word
);
   logic capture;
   assign ready   = !pend;
   assign capture = valid && !pend;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         pend <= 1'b0;
         word <= '0;
      end else begin
         pend <= capture || (pend && !launch);
         if (capture) word <= data;
      end
endmodule

// File: rtl/lcd_page_scheduler.sv
// lcd_page_scheduler: round-robin sharing of the LCD writer between the entry page and the output page
module lcd_page_scheduler
   import lcd_kpn_pkg::*;
#(
   parameter int DWELL_CYCLES   = 50_000_000,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 26
) (
   input logic clock,
   input logic reset,
   lcd_page_scheduler_if.slave bus
);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              last_out;
   logic              e_pend, o1_pend, o2_pend;
   logic [WORD_W-1:0] e_word, o1_word, o2_word;
   logic              launch_e, launch_o, wait_st, expired, done_go, out_pend, pick_e;
   lcd_hold_reg u_hold_entry (.clock(clock), .reset(reset), .valid(bus.entry_valid), .data(bus.entry_data),
      .ready(bus.entry_ready), .launch(launch_e), .pend(e_pend), .word(e_word));
   lcd_hold_reg u_hold_o1 (.clock(clock), .reset(reset), .valid(bus.out1_valid), .data(bus.out1_data),
      .ready(bus.out1_ready), .launch(launch_o), .pend(o1_pend), .word(o1_word));
   lcd_hold_reg u_hold_o2 (.clock(clock), .reset(reset), .valid(bus.out2_valid), .data(bus.out2_data),
      .ready(bus.out2_ready), .launch(launch_o), .pend(o2_pend), .word(o2_word));
   assign launch_e = state == S_E_STROBE;
   assign launch_o = state == S_O1_STROBE;
   assign wait_st  = state inside {S_E_WAIT, S_O1_WAIT, S_O2_WAIT};
   assign expired  = cnt >= TMO_LAST;
   assign done_go  = wait_st && (bus.writer_done || expired);
   assign out_pend = o1_pend || o2_pend;
   // entry wins when it is the only page waiting or the outputs were shown last
   assign pick_e   = e_pend && (!out_pend || last_out);
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      state_nx = pick_e ? S_E_STROBE : out_pend ? S_O1_STROBE : S_IDLE;
         S_E_STROBE:  state_nx = S_E_WAIT;
         S_E_WAIT:    state_nx = done_go ? S_DWELL : S_E_WAIT;
         S_O1_STROBE: state_nx = S_O1_WAIT;
         S_O1_WAIT:   state_nx = !done_go ? S_O1_WAIT : bus.writer_done ? S_O2_STROBE : S_DWELL;
         S_O2_STROBE: state_nx = S_O2_WAIT;
         S_O2_WAIT:   state_nx = done_go ? S_DWELL : S_O2_WAIT;
         S_DWELL:     state_nx = (cnt >= DWELL_LAST) ? S_IDLE : S_DWELL;
         default:     state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state             <= S_IDLE;
         cnt               <= '0;
         last_out          <= 1'b1;
         bus.show_entry_1  <= 1'b0;
         bus.show_output_1 <= 1'b0;
         bus.show_output_2 <= 1'b0;
         bus.entry_1       <= '0;
         bus.output_1      <= '0;
         bus.output_2      <= '0;
         bus.page          <= PAGE_NONE;
         bus.timeout_err   <= 1'b0;
      end else begin
         state             <= state_nx;
         cnt               <= (state_nx != state) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
         bus.show_entry_1  <= launch_e;
         bus.show_output_1 <= launch_o;
         bus.show_output_2 <= state == S_O2_STROBE;
         if (launch_e) bus.entry_1 <= e_word;
         if (launch_o && o1_pend) bus.output_1 <= o1_word;
         if (launch_o && o2_pend) bus.output_2 <= o2_word;
         bus.page <= (state_nx == S_E_STROBE) ? PAGE_ENTRY : (state_nx == S_O1_STROBE) ? PAGE_OUTPUTS : bus.page;
         if (wait_st && expired && !bus.writer_done) bus.timeout_err <= 1'b1;
         if (state == S_DWELL && state_nx == S_IDLE) last_out <= bus.page == PAGE_OUTPUTS;
      end
endmodule

// File: tb/tb_lcd_page_scheduler.sv
// tb_lcd_page_scheduler: directed stimulus with a strobe scoreboard and a simple writer model
module tb_lcd_page_scheduler;
   typedef struct {
      int          kind;
      logic [15:0] e, o1, o2;
      logic [1:0]  pg;
      int          at, gap;
   } exp_t;
   logic clock, reset;
   int   cyc, checks, errors, last_cyc, wr_dly, ns, kind, cap, n;
   logic wr_en;
   exp_t sbq[$];
   exp_t x;
   lcd_page_scheduler_if bus();
   lcd_page_scheduler #(.DWELL_CYCLES(20), .TIMEOUT_CYCLES(30), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .bus(bus));
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   function automatic void expect_strobe(int k, logic [15:0] e, logic [15:0] o1, logic [15:0] o2,
                                         logic [1:0] pg, int at, int gap);
      sbq.push_back('{k, e, o1, o2, pg, at, gap});
   endfunction
   task automatic offer(input logic ev, input logic [15:0] ed, input logic v1, input logic [15:0] d1,
                        input logic v2, input logic [15:0] d2, output int c);
      @(negedge clock);
      bus.entry_valid = ev; bus.entry_data = ed;
      bus.out1_valid  = v1; bus.out1_data  = d1;
      bus.out2_valid  = v2; bus.out2_data  = d2;
      if (ev) chk("entry_ready", bus.entry_ready, 1);
      if (v1) chk("out1_ready", bus.out1_ready, 1);
      if (v2) chk("out2_ready", bus.out2_ready, 1);
      @(negedge clock);
      c = cyc;
      bus.entry_valid = 1'b0; bus.out1_valid = 1'b0; bus.out2_valid = 1'b0;
   endtask
   task automatic chk_reset_vals();
      chk("rst_show_entry_1", bus.show_entry_1, 0);
      chk("rst_show_output_1", bus.show_output_1, 0);
      chk("rst_show_output_2", bus.show_output_2, 0);
      chk("rst_entry_1", bus.entry_1, 0);
      chk("rst_output_1", bus.output_1, 0);
      chk("rst_output_2", bus.output_2, 0);
      chk("rst_page", bus.page, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      chk("rst_entry_ready", bus.entry_ready, 1);
      chk("rst_out1_ready", bus.out1_ready, 1);
      chk("rst_out2_ready", bus.out2_ready, 1);
   endtask
   // scoreboard monitor: every strobe pops one expectation
   always @(negedge clock) if (reset) begin
      ns = int'(bus.show_entry_1) + int'(bus.show_output_1) + int'(bus.show_output_2);
      if (ns > 0) begin
         chk("single_strobe", ns, 1);
         kind = bus.show_output_2 ? 2 : bus.show_output_1 ? 1 : 0;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got strobe kind %0d at cycle %0d, expected none", kind, cyc);
         end else begin
            x = sbq.pop_front();
            chk("strobe_kind", kind, x.kind);
            chk("entry_1", bus.entry_1, x.e);
            chk("output_1", bus.output_1, x.o1);
            chk("output_2", bus.output_2, x.o2);
            chk("page", bus.page, x.pg);
            if (x.at >= 0) chk("strobe_cycle", cyc, x.at);
            if (x.gap >= 0) chk("strobe_gap", cyc - last_cyc, x.gap);
         end
         last_cyc = cyc;
      end
   end
   // writer model: done pulse wr_dly cycles into the WAIT state
   initial begin
      bus.writer_done = 1'b0;
      forever begin
         @(negedge clock);
         if (wr_en && reset && (bus.show_entry_1 || bus.show_output_1 || bus.show_output_2)) begin
            repeat (wr_dly) @(negedge clock);
            bus.writer_done = 1'b1;
            @(negedge clock);
            bus.writer_done = 1'b0;
         end
      end
   end
   initial begin
      cyc = 0; checks = 0; errors = 0; last_cyc = 0;
      wr_en = 1'b1; wr_dly = 2; reset = 1'b0;
      bus.entry_valid = 1'b0; bus.out1_valid = 1'b0; bus.out2_valid = 1'b0;
      bus.entry_data = '0; bus.out1_data = '0; bus.out2_data = '0;
      repeat (3) @(negedge clock);
      chk_reset_vals();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      offer(1, 16'hA5C3, 0, 0, 0, 0, cap);
      chk("entry_ready_pending", bus.entry_ready, 0);
      expect_strobe(0, 16'hA5C3, 0, 0, 1, cap + 2, -1);
      repeat (40) @(negedge clock);
      chk("entry_ready_after", bus.entry_ready, 1);
      offer(0, 0, 1, 16'h1234, 1, 16'h00FF, cap);
      expect_strobe(1, 16'hA5C3, 16'h1234, 16'h00FF, 2, cap + 2, -1);
      expect_strobe(2, 16'hA5C3, 16'h1234, 16'h00FF, 2, -1, 4);
      repeat (40) @(negedge clock);
      offer(1, 16'h0E01, 1, 16'h1111, 1, 16'h2222, cap);
      expect_strobe(0, 16'h0E01, 16'h1234, 16'h00FF, 1, cap + 2, -1);
      expect_strobe(1, 16'h0E01, 16'h1111, 16'h2222, 2, -1, 25);
      expect_strobe(2, 16'h0E01, 16'h1111, 16'h2222, 2, -1, 4);
      repeat (8) @(negedge clock);
      offer(1, 16'h0E02, 0, 0, 0, 0, n);
      expect_strobe(0, 16'h0E02, 16'h1111, 16'h2222, 1, -1, 25);
      repeat (80) @(negedge clock);
      offer(0, 0, 0, 0, 1, 16'hBEEF, cap);
      expect_strobe(1, 16'h0E02, 16'h1111, 16'hBEEF, 2, cap + 2, -1);
      expect_strobe(2, 16'h0E02, 16'h1111, 16'hBEEF, 2, -1, 4);
      repeat (40) @(negedge clock);
      wr_dly = 29;
      offer(1, 16'h5A5A, 0, 0, 0, 0, cap);
      expect_strobe(0, 16'h5A5A, 16'h1111, 16'hBEEF, 1, cap + 2, -1);
      repeat (60) @(negedge clock);
      chk("done_at_expiry_no_err", bus.timeout_err, 0);
      wr_dly = 2;
      wr_en = 1'b0;
      offer(1, 16'h7777, 0, 0, 0, 0, cap);
      expect_strobe(0, 16'h7777, 16'h1111, 16'hBEEF, 1, cap + 2, -1);
      n = 0;
      while (!bus.show_entry_1 && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("timeout_strobe_seen", bus.show_entry_1, 1);
      n = 0;
      while (!bus.timeout_err && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("timeout_cycles", n, 30);
      repeat (60) @(negedge clock);
      chk("timeout_err_sticky", bus.timeout_err, 1);
      offer(0, 0, 1, 16'hCAFE, 1, 16'hF00D, cap);
      expect_strobe(1, 16'h7777, 16'hCAFE, 16'hF00D, 2, cap + 2, -1);
      repeat (4) @(negedge clock);
      chk("o1_wait_page", bus.page, 2);
      reset = 1'b0;
      #1;
      chk_reset_vals();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      wr_en = 1'b1;
      repeat (2) @(negedge clock);
      offer(1, 16'h4321, 0, 0, 0, 0, cap);
      expect_strobe(0, 16'h4321, 0, 0, 1, cap + 2, -1);
      repeat (40) @(negedge clock);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
